// File: rtl/ram_arbiter.sv
// ram_arbiter
//  Shares the single-port data RAM between two requesters:
//    port 0 - cpu LDR/STR path
//    port 1 - loader/debug DMA
//  The owner of the RAM gets one transaction per cycle. Read data comes back
//  one cycle after the read transaction and is steered to the port that
//  issued the read. The RAM macro is 1-cycle synchronous read.
//
//  Arbitration:
//    default build - round-robin with a burst limit of g_MAX_BURST
//                    transactions while the other port is waiting.
//    RAM_ARB_FIXED_PRIO_EN defined - port 0 always wins and preempts port 1
//                    after a single transaction; port 1 may starve.

module ram_arbiter #(
   parameter int g_RAM_WIDTH = 9,
   parameter int g_RAM_ADDR  = 11,
   parameter int g_MAX_BURST = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,

   input  logic                   i_req0,
   input  logic                   i_we0,
   input  logic [g_RAM_ADDR-1:0]  i_addr0,
   input  logic [g_RAM_WIDTH-1:0] i_wdata0,
   output logic                   o_gnt0,
   output logic                   o_rvalid0,
   output logic [g_RAM_WIDTH-1:0] o_rdata0,

   input  logic                   i_req1,
   input  logic                   i_we1,
   input  logic [g_RAM_ADDR-1:0]  i_addr1,
   input  logic [g_RAM_WIDTH-1:0] i_wdata1,
   output logic                   o_gnt1,
   output logic                   o_rvalid1,
   output logic [g_RAM_WIDTH-1:0] o_rdata1,

   output logic                   o_ram_en,
   output logic                   o_ram_we,
   output logic                   o_ram_re,
   output logic [g_RAM_ADDR-1:0]  o_ram_addr,
   output logic [g_RAM_WIDTH-1:0] o_ram_data,
   input  logic [g_RAM_WIDTH-1:0] i_ram_data,

   output logic                   o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic   gnt0_q;
   logic   gnt1_q;
   logic   busy_q;
   logic   rvalid0_q;
   logic   rvalid1_q;

   // A transaction happens whenever the current owner is still requesting.
   logic   txn0;
   logic   txn1;

   assign txn0 = (state == ST_OWN0) && i_req0;
   assign txn1 = (state == ST_OWN1) && i_req1;

`ifndef RAM_ARB_FIXED_PRIO_EN
   localparam int CNT_W = $clog2(g_MAX_BURST + 1);

   // Transactions completed in the current ownership, saturating at the
   // burst limit so a lone requester never wraps the counter.
   logic [CNT_W-1:0] burst_cnt;

   // Port that wins the next tie out of IDLE (the one not served last).
   logic             rr_prio;

   // High when this cycle's transaction uses up the owner's burst allowance.
   logic             burst_done;

   assign burst_done = (int'(burst_cnt) + 1) >= g_MAX_BURST;
`endif

   // Pick the next owner from the current owner and both request lines.
   always_comb begin
      state_nxt = state;
`ifdef RAM_ARB_FIXED_PRIO_EN
      if (i_req0) begin
         state_nxt = ST_OWN0;
      end else if (i_req1) begin
         state_nxt = ST_OWN1;
      end else begin
         state_nxt = ST_IDLE;
      end
`else
      case (state)
         ST_IDLE: begin
            if (i_req0 && i_req1) begin
               state_nxt = rr_prio ? ST_OWN1 : ST_OWN0;
            end else if (i_req0) begin
               state_nxt = ST_OWN0;
            end else if (i_req1) begin
               state_nxt = ST_OWN1;
            end
         end
         ST_OWN0: begin
            if (!i_req0 && !i_req1) begin
               state_nxt = ST_IDLE;
            end else if (i_req1 && (!i_req0 || burst_done)) begin
               state_nxt = ST_OWN1;
            end
         end
         ST_OWN1: begin
            if (!i_req0 && !i_req1) begin
               state_nxt = ST_IDLE;
            end else if (i_req0 && (!i_req1 || burst_done)) begin
               state_nxt = ST_OWN0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
`endif
   end

   // Ownership state plus the registered grant, busy and read-return flags.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         busy_q    <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         gnt0_q    <= (state_nxt == ST_OWN0);
         gnt1_q    <= (state_nxt == ST_OWN1);
         busy_q    <= (state_nxt != ST_IDLE);
         rvalid0_q <= txn0 && !i_we0;
         rvalid1_q <= txn1 && !i_we1;
      end
   end

`ifndef RAM_ARB_FIXED_PRIO_EN
   // Burst accounting and round-robin memory; both restart on every handover.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         burst_cnt <= '0;
         rr_prio   <= 1'b0;
      end else begin
         if (state_nxt != state) begin
            burst_cnt <= '0;
         end else if ((txn0 || txn1) && (int'(burst_cnt) < g_MAX_BURST)) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
         end

         if ((state_nxt != state) && (state_nxt == ST_OWN0)) begin
            rr_prio <= 1'b1;
         end else if ((state_nxt != state) && (state_nxt == ST_OWN1)) begin
            rr_prio <= 1'b0;
         end
      end
   end
`endif

   // The RAM side follows the owner combinationally. With no transaction the
   // address and data simply show port 0, since the RAM ignores them then.
   assign o_ram_en   = txn0 || txn1;
   assign o_ram_we   = (txn0 && i_we0) || (txn1 && i_we1);
   assign o_ram_re   = o_ram_en && !o_ram_we;
   assign o_ram_addr = txn1 ? i_addr1  : i_addr0;
   assign o_ram_data = txn1 ? i_wdata1 : i_wdata0;

   // Read data is shared, qualified per port by its own valid pulse.
   assign o_rvalid0  = rvalid0_q;
   assign o_rvalid1  = rvalid1_q;
   assign o_rdata0   = rvalid0_q ? i_ram_data : '0;
   assign o_rdata1   = rvalid1_q ? i_ram_data : '0;

   assign o_gnt0     = gnt0_q;
   assign o_gnt1     = gnt1_q;
   assign o_busy     = busy_q;

endmodule
